// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared definitions for the audio sample path: default sample width,
//   default pacing divider, the pacer state encoding and the volume
//   scaling function used when a sample is captured.
package audio_pkg;

   localparam int SAMPLE_W        = 16;
   localparam int DEFAULT_CLK_DIV = 1134;  // 50 MHz / ~44.1 kHz

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } pacer_state_t;

   // out = (smp * (volume + 1)) >>> 4, with a 5-bit unsigned gain.
   // |smp| * 16 fits in SAMPLE_W+5 bits, so after the shift the low
   // SAMPLE_W bits always hold the exact result. volume = 15 is unity.
   function automatic logic [SAMPLE_W-1:0] scale_sample(
      input logic [SAMPLE_W-1:0] smp,
      input logic [3:0]          volume
   );
      logic signed [5:0]          gain;
      logic signed [SAMPLE_W+4:0] prod;
      gain = $signed({2'b00, volume} + 6'd1);
      prod = $signed(smp) * gain;
      prod = prod >>> 4;
      return prod[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/sample_pacer_if.sv
// sample_pacer_if
//   Bundles the two handshakes around the pacer.
//   Request side (to/from sine_reader):
//     generate_next  one-cycle request for the next sample
//     sample_ready   sample valid strobe
//     sample         signed sample
//   Output side (to the codec/output stage):
//     out_sample     scaled sample
//     out_valid      out_sample valid
//     out_ready      output stage accepts out_sample
//   master = the pacer, slave = its environment.
interface sample_pacer_if #(
   parameter int SAMPLE_W = audio_pkg::SAMPLE_W
);

   logic                generate_next;
   logic                sample_ready;
   logic [SAMPLE_W-1:0] sample;
   logic [SAMPLE_W-1:0] out_sample;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output generate_next, out_sample, out_valid,
      input  sample_ready, sample, out_ready
   );

   modport slave (
      input  generate_next, out_sample, out_valid,
      output sample_ready, sample, out_ready
   );

endinterface

// File: rtl/rate_divider.sv
// rate_divider
//   Free-running sample-period divider. Counts 0..CLK_DIV-1 while enable
//   is high and is held at 0 while enable is low.
//   Ports:
//     clk     system clock
//     rst     synchronous active-high reset
//     enable  run the divider
//     tick    high in the last cycle of each period while enabled
module rate_divider #(
   parameter int CLK_DIV = audio_pkg::DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (!enable || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/sample_pacer.sv
// sample_pacer
//   Paces sample generation: one generate_next request per divider tick,
//   captures and volume-scales the returned sample, and presents it on a
//   valid/ready output. Missing samples (timeouts) and ticks that arrive
//   while a transaction is still open are counted in miss_count.
//   Ports:
//     clk         system clock
//     rst         synchronous active-high reset
//     enable      allow new sample periods to start
//     volume      gain code 0..15 (15 = unity)
//     bus         sample_pacer_if master (request + output handshakes)
//     miss_count  saturating count of timeouts plus dropped ticks
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a divider tick
//   REQ   | generate_next asserted for this single cycle
//   WAIT  | waiting up to TIMEOUT cycles for sample_ready
//   HOLD  | out_valid high, out_sample frozen until out_ready
module sample_pacer #(
   parameter int CLK_DIV  = audio_pkg::DEFAULT_CLK_DIV,
   parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
   parameter int TIMEOUT  = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [3:0]       volume,
   sample_pacer_if.master   bus,
   output logic [CNT_W-1:0] miss_count
);

   import audio_pkg::pacer_state_t;
   import audio_pkg::IDLE;
   import audio_pkg::REQ;
   import audio_pkg::WAIT;
   import audio_pkg::HOLD;
   import audio_pkg::scale_sample;

   localparam int               TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);
   localparam logic [CNT_W:0]   MISS_MAX = {1'b0, {CNT_W{1'b1}}};

   pacer_state_t        state_q, state_d;
   logic [TW-1:0]       tcnt_q;
   logic [SAMPLE_W-1:0] out_sample_q;
   logic                out_valid_q;
   logic [CNT_W-1:0]    miss_q, miss_d;
   logic                tick;
   logic                capture;
   logic                timeout;
   logic                drop;
   logic [1:0]          miss_inc;
   logic [CNT_W:0]      miss_sum;

   rate_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_rate_divider (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: if (tick) state_d = REQ;
         REQ:  state_d = WAIT;
         WAIT: begin
            // A sample arriving in the final wait cycle beats the timeout.
            if (bus.sample_ready) begin
               capture = 1'b1;
               state_d = HOLD;
            end else if (tcnt_q == T_LAST) begin
               timeout = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A tick outside IDLE is discarded; it and a timeout can both land in
   // the same cycle, so the increment is 0..2.
   always_comb begin
      drop     = tick && (state_q != IDLE);
      miss_inc = {1'b0, drop} + {1'b0, timeout};
      miss_sum = {1'b0, miss_q} + (CNT_W + 1)'(miss_inc);
      if (miss_sum > MISS_MAX) begin
         miss_d = {CNT_W{1'b1}};
      end else begin
         miss_d = miss_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         tcnt_q       <= '0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
         miss_q       <= '0;
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
         tcnt_q  <= (state_q == WAIT) ? tcnt_q + 1'b1 : '0;
         // On a timeout out_sample is left alone so the last sample repeats.
         if (capture) begin
            out_sample_q <= scale_sample(bus.sample, volume);
         end
         if (capture || timeout) begin
            out_valid_q <= 1'b1;
         end else if ((state_q == HOLD) && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.generate_next = (state_q == REQ);
   assign bus.out_sample    = out_sample_q;
   assign bus.out_valid     = out_valid_q;
   assign miss_count        = miss_q;

endmodule

// File: tb/tb_sample_pacer.sv
module tb_sample_pacer;

   localparam int SW = 16;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       enable  = 1'b0;
   logic [3:0] volume  = 4'd15;
   logic [7:0] miss_count;

   int checks = 0;
   int errors = 0;

   // sine_reader model: when resp_en, answers one cycle after generate_next
   bit resp_en     = 1'b0;
   bit force_ready = 1'b0;
   bit pend        = 1'b0;

   sample_pacer_if #(.SAMPLE_W(SW)) bus ();

   sample_pacer #(
      .CLK_DIV  (8),
      .SAMPLE_W (SW),
      .TIMEOUT  (16),
      .CNT_W    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .volume     (volume),
      .bus        (bus),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   // One clock cycle: observe at the falling edge, then update the model.
   task automatic cycle();
      @(negedge clk);
      if (resp_en) begin
         bus.sample_ready = pend;
         pend             = bus.generate_next;
      end else begin
         bus.sample_ready = force_ready;
         pend             = 1'b0;
      end
   endtask

   // Leaves rst low at the falling edge of the first post-reset cycle.
   task automatic do_reset(input bit en);
      rst    = 1'b1;
      enable = en;
      cycle();
      cycle();
      rst              = 1'b0;
      pend             = 1'b0;
      bus.sample_ready = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (bus.out_valid !== 1'b1 && n < 40);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_valid: out_valid=%0b after %0d cycles, required 1", bus.out_valid, n);
      end
   endtask

   task automatic wait_gen(output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (bus.generate_next !== 1'b1 && n < 20);
      checks++;
      if (bus.generate_next !== 1'b1) begin
         errors++;
         $display("FAIL wait_gen: generate_next=%0b after %0d cycles, required 1", bus.generate_next, n);
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      enable = 1'b1;
      cycle();
      cycle();
      cycle();
      checks++;
      if (bus.generate_next !== 1'b0) begin errors++; $display("FAIL reset_gen: got %0b want 0", bus.generate_next); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
      checks++;
      if (bus.out_sample !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h want 0000", bus.out_sample); end
      checks++;
      if (miss_count !== 8'h00) begin errors++; $display("FAIL reset_miss: got %h want 00", miss_count); end
   endtask

   task automatic test_pacing();
      int gens, valids, last_gen;
      bit prev_gen, prev_valid;
      gens = 0; valids = 0; last_gen = -1; prev_gen = 0; prev_valid = 0;
      resp_en       = 1'b1;
      volume        = 4'd15;
      bus.sample    = 16'h4000;
      bus.out_ready = 1'b1;
      do_reset(1'b1);
      // observation i is post-reset cycle i; first tick in cycle 7
      for (int i = 1; i <= 48; i++) begin
         cycle();
         if (bus.generate_next === 1'b1) begin
            checks++;
            if (prev_gen) begin errors++; $display("FAIL pace_width: generate_next high 2 cycles at %0d, want 1", i); end
            checks++;
            if ((last_gen < 0 && i != 8) || (last_gen >= 0 && i - last_gen != 8)) begin
               errors++; $display("FAIL pace_gap: pulse at %0d prev %0d, want spacing 8 (first at 8)", i, last_gen);
            end
            last_gen = i;
            gens++;
         end
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (bus.out_sample !== 16'h4000) begin errors++; $display("FAIL pace_sample: got %h want 4000", bus.out_sample); end
            checks++;
            if (prev_valid) begin errors++; $display("FAIL pace_valid_width: out_valid high 2 cycles at %0d", i); end
            valids++;
         end
         prev_gen   = bus.generate_next;
         prev_valid = bus.out_valid;
      end
      checks++;
      if (gens != 6) begin errors++; $display("FAIL pace_gen_count: got %0d want 6", gens); end
      checks++;
      if (valids != 5) begin errors++; $display("FAIL pace_valid_count: got %0d want 5", valids); end
      checks++;
      if (miss_count !== 8'h00) begin errors++; $display("FAIL pace_miss: got %h want 00", miss_count); end
   endtask

   task automatic test_scaling();
      volume     = 4'd7;
      bus.sample = 16'h8000;
      wait_valid();
      checks++;
      if (bus.out_sample !== 16'hC000) begin errors++; $display("FAIL scale_neg_full: got %h want C000", bus.out_sample); end
      bus.sample = 16'h7FFF;
      wait_valid();
      checks++;
      if (bus.out_sample !== 16'h3FFF) begin errors++; $display("FAIL scale_pos_full: got %h want 3FFF", bus.out_sample); end
      volume     = 4'd0;
      bus.sample = 16'h0010;
      wait_valid();
      checks++;
      if (bus.out_sample !== 16'h0001) begin errors++; $display("FAIL scale_vol0: got %h want 0001", bus.out_sample); end
      checks++;
      if (miss_count !== 8'h00) begin errors++; $display("FAIL scale_miss: got %h want 00", miss_count); end
   endtask

   task automatic test_timeout();
      int n, k;
      volume     = 4'd15;
      bus.sample = 16'h4000;
      wait_valid();
      checks++;
      if (bus.out_sample !== 16'h4000) begin errors++; $display("FAIL timeout_pre: got %h want 4000", bus.out_sample); end
      resp_en    = 1'b0;
      bus.sample = 16'h1234;
      wait_gen(n);
      k = 0;
      do begin
         cycle();
         k++;
      end while (bus.out_valid !== 1'b1 && k < 40);
      checks++;
      if (k != 17) begin errors++; $display("FAIL timeout_latency: out_valid after %0d cycles, want 17", k); end
      checks++;
      if (bus.out_sample !== 16'h4000) begin errors++; $display("FAIL timeout_repeat: got %h want 4000", bus.out_sample); end
      // one timeout plus the two ticks (8 and 16 cycles after the request tick) dropped while waiting
      checks++;
      if (miss_count !== 8'd3) begin errors++; $display("FAIL timeout_miss: got %0d want 3", miss_count); end
   endtask

   task automatic test_back_to_back_stall();
      int n;
      resp_en       = 1'b1;
      volume        = 4'd15;
      bus.sample    = 16'h4000;
      bus.out_ready = 1'b1;
      do_reset(1'b1);
      wait_valid();
      checks++;
      if (miss_count !== 8'd0) begin errors++; $display("FAIL stall_pre_miss: got %0d want 0", miss_count); end
      bus.out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'h4000) begin
            errors++; $display("FAIL stall_hold: cycle %0d valid=%0b sample=%h want 1/4000", i, bus.out_valid, bus.out_sample);
         end
         checks++;
         if (bus.generate_next !== 1'b0) begin errors++; $display("FAIL stall_gen: cycle %0d got 1 want 0", i); end
      end
      checks++;
      if (miss_count !== 8'd2) begin errors++; $display("FAIL stall_miss: got %0d want 2", miss_count); end
      bus.out_ready = 1'b1;
      wait_gen(n);
      checks++;
      if (n != 2) begin errors++; $display("FAIL stall_resume: generate_next after %0d cycles want 2", n); end
      wait_valid();
      checks++;
      if (bus.out_sample !== 16'h4000) begin errors++; $display("FAIL stall_resume_sample: got %h want 4000", bus.out_sample); end
      checks++;
      if (miss_count !== 8'd2) begin errors++; $display("FAIL stall_resume_miss: got %0d want 2", miss_count); end
   endtask

   task automatic test_reset_mid();
      int n;
      resp_en = 1'b0;
      wait_gen(n);
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (bus.generate_next !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_ctrl: gen=%0b valid=%0b want 0/0", bus.generate_next, bus.out_valid);
      end
      checks++;
      if (bus.out_sample !== 16'h0000) begin errors++; $display("FAIL midrst_sample: got %h want 0000", bus.out_sample); end
      checks++;
      if (miss_count !== 8'd0) begin errors++; $display("FAIL midrst_miss: got %0d want 0", miss_count); end
      force_ready = 1'b1;
      cycle();
      force_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (bus.out_valid !== 1'b0 || bus.generate_next !== 1'b0) begin
            errors++; $display("FAIL midrst_late_ready: cycle %0d valid=%0b gen=%0b want 0/0", i, bus.out_valid, bus.generate_next);
         end
      end
   endtask

   task automatic test_enable();
      int n;
      resp_en    = 1'b1;
      pend       = 1'b0;
      volume     = 4'd15;
      bus.sample = 16'h0100;
      wait_gen(n);
      enable = 1'b0;
      wait_valid();
      checks++;
      if (bus.out_sample !== 16'h0100) begin errors++; $display("FAIL enable_complete: got %h want 0100", bus.out_sample); end
      for (int i = 0; i < 50; i++) begin
         cycle();
         checks++;
         if (bus.generate_next !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL enable_off: cycle %0d gen=%0b valid=%0b want 0/0", i, bus.generate_next, bus.out_valid);
         end
      end
   endtask

   task automatic test_saturation();
      int nv, cyc;
      nv  = 0;
      cyc = 0;
      resp_en       = 1'b0;
      bus.out_ready = 1'b1;
      do_reset(1'b1);
      // each 24-cycle period: one timeout and two dropped ticks
      while (nv < 260 && cyc < 7000) begin
         cycle();
         cyc++;
         if (bus.out_valid === 1'b1) begin
            nv++;
            if (nv == 10) begin
               checks++;
               if (miss_count !== 8'd30) begin errors++; $display("FAIL sat_10: got %0d want 30", miss_count); end
            end
            if (nv == 84) begin
               checks++;
               if (miss_count !== 8'd252) begin errors++; $display("FAIL sat_84: got %0d want 252", miss_count); end
            end
         end
      end
      checks++;
      if (nv != 260) begin errors++; $display("FAIL sat_budget: %0d timeouts seen want 260", nv); end
      checks++;
      if (miss_count !== 8'hFF) begin errors++; $display("FAIL sat_final: got %h want FF", miss_count); end
   endtask

   initial begin
      bus.sample_ready = 1'b0;
      bus.sample       = '0;
      bus.out_ready    = 1'b1;
      test_reset();
      test_pacing();
      test_scaling();
      test_timeout();
      test_back_to_back_stall();
      test_reset_mid();
      test_enable();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
